// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor: recovers pixel position from VGA sync edges, checks the
// line/frame timing and reports per-pixel coordinates and colour, a lock
// flag and one-cycle error pulses.
//
// Pipeline (pin sample k lands in *_r at edge k):
//   edge k+1 : counters, sync edge detect, raw timing checks (*_q flags)
//   edge k+2 : FSM, pixel outputs, error pulses, err_count
module vga_sync_monitor #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk_pixel,
    input  logic       rst,
    input  logic       hsync,
    input  logic       vsync,
    input  logic [2:0] red,
    input  logic [2:0] green,
    input  logic [1:0] blue,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic [7:0] pix_data,
    output logic       pix_valid,
    output logic       frame_start,
    output logic       locked,
    output logic       err_hsync,
    output logic       err_line,
    output logic       err_vsync,
    output logic       err_frame,
    output logic       err_blank,
    output logic [7:0] err_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam logic [9:0] H_START = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] H_END   = 10'(H_SYNC + H_BACK + H_VISIBLE);
    localparam logic [9:0] V_START = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] V_END   = 10'(V_SYNC + V_BACK + V_VISIBLE);
    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNC_W = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_W = 10'(V_SYNC);
    localparam logic [9:0] CNT_MAX = 10'd1023;

    typedef enum logic [1:0] {HUNT, H_LOCK, MEASURE, LOCKED} state_t;
    state_t state, state_nxt;

    logic       hsync_r, vsync_r, hsync_d;
    logic [7:0] rgb_r, rgb_d;
    logic [9:0] hcnt, vcnt, hlow, vlow;
    logic       vs_line;
    logic       h_fall_q, v_fall_q;
    logic       bad_hsync_q, bad_line_q, bad_vsync_q, bad_frame_q;

    // Edge events seen on the registered pins; vertical edges only count at line starts.
    logic h_fall, h_rise, v_fall, v_rise;
    assign h_fall = hsync_d & ~hsync_r;
    assign h_rise = ~hsync_d & hsync_r;
    assign v_fall = h_fall & vs_line & ~vsync_r;
    assign v_rise = h_fall & ~vs_line & vsync_r;

    // Pin capture and one extra stage for edge detect / colour alignment.
    // Sync registers idle high so release from reset does not fake an edge.
    always_ff @(posedge clk_pixel) begin
        if (!rst) begin
            hsync_r <= 1'b1;
            vsync_r <= 1'b1;
            hsync_d <= 1'b1;
            rgb_r   <= '0;
            rgb_d   <= '0;
        end else begin
            hsync_r <= hsync;
            vsync_r <= vsync;
            hsync_d <= hsync_r;
            rgb_r   <= {red, green, blue};
            rgb_d   <= rgb_r;
        end
    end

    // Position counters, sync-low width counters and raw timing checks.
    always_ff @(posedge clk_pixel) begin
        if (!rst) begin
            hcnt        <= '0;
            vcnt        <= '0;
            hlow        <= '0;
            vlow        <= '0;
            vs_line     <= 1'b1;
            h_fall_q    <= 1'b0;
            v_fall_q    <= 1'b0;
            bad_hsync_q <= 1'b0;
            bad_line_q  <= 1'b0;
            bad_vsync_q <= 1'b0;
            bad_frame_q <= 1'b0;
        end else begin
            if (h_fall)
                hcnt <= '0;
            else if (hcnt != CNT_MAX)
                hcnt <= hcnt + 10'd1;

            if (h_fall)
                hlow <= 10'd1;
            else if (!hsync_r && hlow != CNT_MAX)
                hlow <= hlow + 10'd1;

            if (h_fall) begin
                vs_line <= vsync_r;
                if (v_fall)
                    vcnt <= '0;
                else if (vcnt != CNT_MAX)
                    vcnt <= vcnt + 10'd1;
                if (v_fall)
                    vlow <= 10'd1;
                else if (!vsync_r && vlow != CNT_MAX)
                    vlow <= vlow + 10'd1;
            end

            h_fall_q    <= h_fall;
            v_fall_q    <= v_fall;
            bad_hsync_q <= h_rise && (hlow != H_SYNC_W);
            // Wrong line length at a line start, or a stalled line hitting
            // saturation (flagged only on the step into 1023, so once).
            bad_line_q  <= (h_fall && hcnt != H_LAST) ||
                           (!h_fall && hcnt == CNT_MAX - 10'd1);
            bad_vsync_q <= v_rise && (vlow != V_SYNC_W);
            bad_frame_q <= v_fall && (vcnt != V_LAST);
        end
    end

    // Qualified errors, visibility and lock FSM next state.
    logic       chk_h, chk_f, vis, any_err, pv_nxt;
    logic       e_hsync, e_line, e_vsync, e_frame, e_blank;
    logic [2:0] n_err;
    logic [8:0] cnt_sum;
    always_comb begin
        chk_h   = (state != HUNT);
        // The first frame after H_LOCK has no anchored vcnt, so frame length
        // is only judged from MEASURE on.
        chk_f   = (state == MEASURE) || (state == LOCKED);
        vis     = (hcnt >= H_START) && (hcnt < H_END) &&
                  (vcnt >= V_START) && (vcnt < V_END);
        e_hsync = chk_h & bad_hsync_q;
        e_line  = chk_h & bad_line_q;
        e_vsync = chk_h & bad_vsync_q;
        e_frame = chk_f & bad_frame_q;
        e_blank = (state == LOCKED) & ~vis & (|rgb_d);
        any_err = e_hsync | e_line | e_vsync | e_frame;
        pv_nxt  = vis & chk_f;
        n_err   = 3'(e_hsync) + 3'(e_line) + 3'(e_vsync) + 3'(e_frame) + 3'(e_blank);
        cnt_sum = {1'b0, err_count} + {6'd0, n_err};

        state_nxt = state;
        case (state)
            HUNT:    if (h_fall_q) state_nxt = H_LOCK;
            H_LOCK:  if (v_fall_q) state_nxt = MEASURE;
            MEASURE: if (v_fall_q) state_nxt = LOCKED;
            default: state_nxt = state;
        endcase
        // A timing error overrides any advance made in the same cycle.
        if (any_err)
            state_nxt = HUNT;
    end

    // State register and all registered outputs.
    always_ff @(posedge clk_pixel) begin
        if (!rst) begin
            state       <= HUNT;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_data    <= '0;
            pix_valid   <= 1'b0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
            err_hsync   <= 1'b0;
            err_line    <= 1'b0;
            err_vsync   <= 1'b0;
            err_frame   <= 1'b0;
            err_blank   <= 1'b0;
            err_count   <= '0;
        end else begin
            state       <= state_nxt;
            pix_x       <= vis ? hcnt - H_START : '0;
            pix_y       <= vis ? vcnt - V_START : '0;
            pix_data    <= rgb_d;
            pix_valid   <= pv_nxt;
            frame_start <= pv_nxt && (hcnt == H_START) && (vcnt == V_START);
            locked      <= (state_nxt == LOCKED);
            err_hsync   <= e_hsync;
            err_line    <= e_line;
            err_vsync   <= e_vsync;
            err_frame   <= e_frame;
            err_blank   <= e_blank;
            err_count   <= cnt_sum[8] ? 8'd255 : cnt_sum[7:0];
        end
    end

endmodule

// File: tb/tb_vga_sync_monitor.sv
// tb_vga_sync_monitor: directed VGA frames on a scaled-down timing (15x9),
// expected pixels and error pulses queued by the driver, checked by a monitor.
module tb_vga_sync_monitor;

    localparam int HV = 8, HF = 2, HS = 3, HB = 2;
    localparam int VV = 4, VF = 1, VS = 2, VB = 2;
    localparam int HT = HV + HF + HS + HB;   // 15
    localparam int VT = VV + VF + VS + VB;   // 9
    localparam logic [4:0] E_HS = 5'b10000, E_LN = 5'b01000, E_VS = 5'b00100,
                           E_FR = 5'b00010, E_BL = 5'b00001, E_NO = 5'b00000;

    logic       clk_pixel = 1'b0, rst = 1'b0, hsync = 1'b1, vsync = 1'b1;
    logic [2:0] red = '0, green = '0;
    logic [1:0] blue = '0;
    logic [9:0] pix_x, pix_y;
    logic [7:0] pix_data, err_count;
    logic       pix_valid, frame_start, locked;
    logic       err_hsync, err_line, err_vsync, err_frame, err_blank;

    vga_sync_monitor #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .clk_pixel(clk_pixel), .rst(rst), .hsync(hsync), .vsync(vsync),
        .red(red), .green(green), .blue(blue),
        .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data), .pix_valid(pix_valid),
        .frame_start(frame_start), .locked(locked),
        .err_hsync(err_hsync), .err_line(err_line), .err_vsync(err_vsync),
        .err_frame(err_frame), .err_blank(err_blank), .err_count(err_count)
    );

    always #20 clk_pixel = ~clk_pixel;

    int cyc = 0, n_cmp = 0, n_bad = 0, fnum = 0;
    always @(posedge clk_pixel) cyc <= cyc + 1;

    typedef struct { int cyc; logic [28:0] v; } pix_t;
    typedef struct { int cyc; logic [4:0]  v; } err_t;
    pix_t pq[$];
    err_t eq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every output pixel / error pulse must match the head of its queue.
    pix_t pm;
    err_t em;
    logic [4:0] ev_m;
    always @(negedge clk_pixel) begin
        ev_m = {err_hsync, err_line, err_vsync, err_frame, err_blank};
        chk("frame_start_without_pixel", 32'(frame_start & ~pix_valid), 32'd0);
        if (pix_valid === 1'b1) begin
            if (pq.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL pix_unexpected: got x=%0d y=%0d, want no pixel (cycle %0d)", pix_x, pix_y, cyc);
            end else begin
                pm = pq.pop_front();
                chk("pix_cycle", 32'(cyc), 32'(pm.cyc));
                chk("pix_xy_data_fs", 32'({pix_x, pix_y, pix_data, frame_start}), 32'(pm.v));
            end
        end
        if (ev_m != 5'd0) begin
            if (eq.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL err_unexpected: got errs=%b, want none (cycle %0d)", ev_m, cyc);
            end else begin
                em = eq.pop_front();
                chk("err_cycle", 32'(cyc), 32'(em.cyc));
                chk("err_vector", 32'(ev_m), 32'(em.v));
            end
        end
    end

    function automatic logic [7:0] pattern(input int x, input int y);
        return 8'(x * 37 + y * 11 + fnum * 3 + 1);
    endfunction

    // One line of hd samples. A short hsync expects err_hsync at its rise; a
    // line stretched past 1023 expects err_line at hd 1023 (used only while checking).
    task automatic run_line(input int vd, input int hs_len, input int line_len, input bit vs_low,
                            input bit push, input logic [4:0] e_start, input int blank_hd);
        bit vis;
        logic [7:0] px;
        logic [4:0] e;
        int x, y;
        for (int hd = 0; hd < line_len; hd++) begin
            @(posedge clk_pixel); #1;
            x   = hd - HS - HB;
            y   = vd - VS - VB;
            vis = (x >= 0) && (x < HV) && (y >= 0) && (y < VV);
            px  = vis ? pattern(x, y) : ((hd == blank_hd) ? 8'hE0 : 8'h00);
            hsync = (hd < hs_len) ? 1'b0 : 1'b1;
            vsync = vs_low ? 1'b0 : 1'b1;
            {red, green, blue} = px;
            if (vis && push)
                pq.push_back('{cyc + 3, {10'(x), 10'(y), px, (x == 0 && y == 0)}});
            e = E_NO;
            if (hd == 0)        e |= e_start;
            if (hs_len != HS && hd == hs_len) e |= E_HS;
            if (hd == 1023)     e |= E_LN;
            if (hd == blank_hd) e |= E_BL;
            if (e != E_NO) eq.push_back('{cyc + 3, e});
        end
    endtask

    task automatic run_frame(input bit push, input int hs0, input int vs_len, input int vtot,
                             input int last_len, input logic [4:0] e_start,
                             input logic [4:0] e_vrise, input int blank_hd);
        for (int vd = 0; vd < vtot; vd++)
            run_line(vd, (vd == 0) ? hs0 : HS, (vd == vtot - 1) ? last_len : HT, vd < vs_len, push,
                     ((vd == 0) ? e_start : E_NO) | ((vd == vs_len) ? e_vrise : E_NO), blank_hd);
        fnum++;
    endtask

    task automatic nominal(input bit push);
        run_frame(push, HS, VS, VT, HT, E_NO, E_NO, -1);
    endtask

    task automatic expect_state(input string nm, input logic lk, input logic [7:0] cnt);
        @(negedge clk_pixel);
        chk({nm, "_locked"}, 32'(locked), 32'(lk));
        chk({nm, "_err_count"}, 32'(err_count), 32'(cnt));
    endtask

    initial begin
        // Reset with random pins: every output must stay at zero.
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk_pixel); #1;
            hsync = 1'($urandom_range(0, 1));
            vsync = 1'($urandom_range(0, 1));
            {red, green, blue} = 8'($urandom);
            @(negedge clk_pixel);
            chk("rst_pix", 32'({pix_x, pix_y, pix_data}), 32'd0);
            chk("rst_flags", 32'({pix_valid, frame_start, locked, err_hsync, err_line,
                                  err_vsync, err_frame, err_blank}), 32'd0);
            chk("rst_err_count", 32'(err_count), 32'd0);
        end
        @(posedge clk_pixel); #1;
        hsync = 1'b1; vsync = 1'b1; {red, green, blue} = 8'h00;
        @(posedge clk_pixel); #1;
        rst = 1'b1;
        repeat (4) @(posedge clk_pixel);
        #1;

        // Enter mid-frame: first hsync fall -> H_LOCK, then two vsync falls -> LOCKED.
        run_line(VT - 2, HS, HT, 1'b0, 1'b0, E_NO, -1);
        run_line(VT - 1, HS, HT, 1'b0, 1'b0, E_NO, -1);
        nominal(1'b1);                                   // MEASURE
        expect_state("after_first_vfall", 1'b0, 8'd0);
        nominal(1'b1);                                   // LOCKED
        expect_state("after_second_vfall", 1'b1, 8'd0);
        nominal(1'b1);

        // Short hsync on line 0 while locked.
        run_frame(1'b0, HS - 1, VS, VT, HT, E_NO, E_NO, -1);
        expect_state("short_hsync", 1'b0, 8'd1);
        nominal(1'b1);
        nominal(1'b1);
        expect_state("relock_1", 1'b1, 8'd1);

        // One line one cycle too long (last line of the frame).
        run_frame(1'b1, HS, VS, VT, HT + 1, E_NO, E_NO, -1);
        run_frame(1'b0, HS, VS, VT, HT, E_LN, E_NO, -1);
        expect_state("long_line", 1'b0, 8'd2);
        nominal(1'b1);
        run_frame(1'b1, HS, VS, VT, HT, E_NO, E_NO, -1);
        expect_state("relock_2", 1'b1, 8'd2);

        // Stalled hsync: the last line runs far past saturation.
        run_frame(1'b1, HS, VS, VT, 1100, E_NO, E_NO, -1);
        expect_state("stall", 1'b0, 8'd3);
        nominal(1'b0);                                   // line 0 fall -> H_LOCK
        nominal(1'b1);                                   // MEASURE
        nominal(1'b1);                                   // LOCKED
        expect_state("relock_3", 1'b1, 8'd3);

        // Colour in blanking: one event per line, 297 events -> saturation.
        run_frame(1'b1, HS, VS, VT, HT, E_NO, E_NO, 1);
        expect_state("blank_first_frame", 1'b1, 8'd12);
        for (int f = 0; f < 32; f++)
            run_frame(1'b1, HS, VS, VT, HT, E_NO, E_NO, 1);
        expect_state("blank_saturate", 1'b1, 8'd255);

        // 10-line frame -> err_frame; then a 3-line vsync -> err_vsync.
        run_frame(1'b1, HS, VS, VT + 1, HT, E_NO, E_NO, -1);
        run_frame(1'b0, HS, VS, VT, HT, E_FR, E_NO, -1);
        expect_state("long_frame", 1'b0, 8'd255);
        run_frame(1'b0, HS, VS + 1, VT, HT, E_NO, E_VS, -1);
        expect_state("wide_vsync", 1'b0, 8'd255);
        nominal(1'b1);                                   // back in MEASURE

        @(posedge clk_pixel); #1;
        hsync = 1'b1; vsync = 1'b1; {red, green, blue} = 8'h00;
        repeat (8) @(negedge clk_pixel);
        chk("pixels_outstanding", 32'(pq.size()), 32'd0);
        chk("errors_outstanding", 32'(eq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
